// File: rtl/preg_free_list_pkg.sv
// Shared rename constants: physical/architectural register counts and the tag type
// used by the free list, rename stage and RAT.
package preg_free_list_pkg;

  localparam int NUM_PREGS  = 64;
  localparam int NUM_AREGS  = 32;
  localparam int TAG_W      = 6;
  localparam int FL_DEPTH   = NUM_PREGS - NUM_AREGS;
  localparam int FREE_CNT_W = $clog2(FL_DEPTH + 1);

  typedef logic [TAG_W-1:0] preg_tag_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Two-slot allocate / two-slot release port of the physical register free list.
// master = rename/retire side, slave = the free list itself.
interface preg_free_list_if;
  import preg_free_list_pkg::*;

  logic [1:0]            alloc_req;
  logic [1:0]            alloc_gnt;
  preg_tag_t             alloc_tag0;
  preg_tag_t             alloc_tag1;
  logic [1:0]            free_vld;
  preg_tag_t             free_tag0;
  preg_tag_t             free_tag1;
  logic [FREE_CNT_W-1:0] free_count;
  logic                  empty;
  logic                  err;

  modport master (
    output alloc_req, free_vld, free_tag0, free_tag1,
    input  alloc_gnt, alloc_tag0, alloc_tag1, free_count, empty, err
  );

  modport slave (
    input  alloc_req, free_vld, free_tag0, free_tag1,
    output alloc_gnt, alloc_tag0, alloc_tag1, free_count, empty, err
  );

endinterface

// File: rtl/preg_free_list.sv
// Physical register free list: circular FIFO of free tags, 2 allocs + 2 frees per cycle.
// Optional FREE_LIST_CHECK_EN adds an in-list bitmap that flags illegal frees on err.
module preg_free_list #(
  parameter int NUM_PREGS = preg_free_list_pkg::NUM_PREGS,
  parameter int NUM_AREGS = preg_free_list_pkg::NUM_AREGS,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  preg_free_list_if.slave   bus
);
  import preg_free_list_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  preg_tag_t        fifo [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head1, head_nxt, tail1, tail_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W:0]   room;
  logic             gnt0, gnt1;
  logic             ok0, ok1, acc0, acc1;
  logic             empty_q;

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic                 err_q;
  logic                 err_set;
`endif

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Grants are gated by rst_n so nothing is handed out while the list reloads.
  always_comb begin
    gnt0     = rst_n & bus.alloc_req[0] & (cnt >= CNT_W'(1));
    gnt1     = rst_n & bus.alloc_req[1] & (cnt >= (CNT_W'(1) + CNT_W'(gnt0)));
    head1    = ptr_add(head, {1'b0, gnt0});
    head_nxt = ptr_add(head, pop2({gnt1, gnt0}));
  end

  assign bus.alloc_gnt  = {gnt1, gnt0};
  assign bus.alloc_tag0 = fifo[head];
  assign bus.alloc_tag1 = fifo[head1];

  // Room counts slots popped this cycle; slot 1 loses first when room runs out.
  always_comb begin
    room = (CNT_W+1)'(DEPTH) - {1'b0, cnt} + (CNT_W+1)'(pop2({gnt1, gnt0}));
`ifdef FREE_LIST_CHECK_EN
    ok0 = bus.free_vld[0] & (bus.free_tag0 >= preg_tag_t'(NUM_AREGS))
          & ~in_list[bus.free_tag0];
    ok1 = bus.free_vld[1] & (bus.free_tag1 >= preg_tag_t'(NUM_AREGS))
          & ~in_list[bus.free_tag1]
          & ~(ok0 & (bus.free_tag1 == bus.free_tag0));
`else
    ok0 = bus.free_vld[0];
    ok1 = bus.free_vld[1];
`endif
    acc0     = ok0 & (room >= (CNT_W+1)'(1));
    acc1     = ok1 & (room >= ((CNT_W+1)'(1) + (CNT_W+1)'(acc0)));
    tail1    = ptr_add(tail, {1'b0, acc0});
    tail_nxt = ptr_add(tail, pop2({acc1, acc0}));
    cnt_nxt  = cnt - CNT_W'(pop2({gnt1, gnt0})) + CNT_W'(pop2({acc1, acc0}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= preg_tag_t'(NUM_AREGS + i);
      head    <= '0;
      tail    <= '0;
      cnt     <= CNT_W'(DEPTH);
      empty_q <= 1'b0;
    end else begin
      if (acc0) fifo[tail]  <= bus.free_tag0;
      if (acc1) fifo[tail1] <= bus.free_tag1;
      head    <= head_nxt;
      tail    <= tail_nxt;
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
    end
  end

  assign bus.free_count = FREE_CNT_W'(cnt);
  assign bus.empty      = empty_q;

`ifdef FREE_LIST_CHECK_EN
  // Any requested free that was not accepted is a protocol violation.
  assign err_set = (bus.free_vld[0] & ~acc0) | (bus.free_vld[1] & ~acc1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) in_list[i] <= (i >= NUM_AREGS);
      err_q <= 1'b0;
    end else begin
      if (gnt0) in_list[bus.alloc_tag0] <= 1'b0;
      if (gnt1) in_list[bus.alloc_tag1] <= 1'b0;
      if (acc0) in_list[bus.free_tag0]  <= 1'b1;
      if (acc1) in_list[bus.free_tag1]  <= 1'b1;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: vector table, drain/no-bypass/wrap sequences,
// mid-stream async reset, and illegal-free handling (build-dependent err).
module tb_preg_free_list;
  import preg_free_list_pkg::*;

`ifdef FREE_LIST_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] req;
    logic [1:0] vld;
    int         t0;
    int         t1;
    logic [1:0] gnt;
    int         e0;
    int         e1;
    int         cnt;
    logic       emp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   fl_q[$];
  int   out_q[$];
  vec_t tbl[5];

  preg_free_list_if bus();

  preg_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string what, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
    end
  endtask

  // Drive one cycle: grants/tags checked before the edge, registered outputs after it.
  task automatic apply_stimulus(input string what, input logic [1:0] req, input logic [1:0] vld,
                                input int t0, input int t1, input logic [1:0] exp_gnt,
                                input int exp_t0, input int exp_t1, input int exp_cnt,
                                input logic exp_empty, input logic exp_err);
    @(negedge clk);
    bus.alloc_req = req;
    bus.free_vld  = vld;
    bus.free_tag0 = preg_tag_t'(t0);
    bus.free_tag1 = preg_tag_t'(t1);
    #1;
    check_output({what, ".gnt"}, int'(bus.alloc_gnt), int'(exp_gnt));
    if (exp_gnt[0]) check_output({what, ".tag0"}, int'(bus.alloc_tag0), exp_t0);
    if (exp_gnt[1]) check_output({what, ".tag1"}, int'(bus.alloc_tag1), exp_t1);
    @(posedge clk);
    #1;
    check_output({what, ".count"}, int'(bus.free_count), exp_cnt);
    check_output({what, ".empty"}, int'(bus.empty), int'(exp_empty));
    check_output({what, ".err"}, int'(bus.err), int'(exp_err));
    bus.alloc_req = '0;
    bus.free_vld  = '0;
  endtask

  // Legal traffic against a queue model: frees return the oldest outstanding tags.
  task automatic run_model_cycle(input string what, input logic [1:0] req, input logic [1:0] vld);
    int   n, e0, e1, f0, f1, c;
    logic g0, g1;
    n  = fl_q.size();
    g0 = req[0] && (n >= 1);
    g1 = req[1] && (n >= (g0 ? 2 : 1));
    e0 = g0 ? fl_q[0] : 0;
    e1 = g1 ? fl_q[g0 ? 1 : 0] : 0;
    f0 = 0;
    f1 = 0;
    if (vld[0]) f0 = out_q.pop_front();
    if (vld[1]) f1 = out_q.pop_front();
    c = n - int'(g0) - int'(g1) + int'(vld[0]) + int'(vld[1]);
    apply_stimulus(what, req, vld, f0, f1, {g1, g0}, e0, e1, c, (c == 0), 1'b0);
    if (g0) out_q.push_back(fl_q.pop_front());
    if (g1) out_q.push_back(fl_q.pop_front());
    if (vld[0]) fl_q.push_back(f0);
    if (vld[1]) fl_q.push_back(f1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.alloc_req = '0;
    bus.free_vld  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.alloc_req = 2'b11;
    bus.free_vld  = '0;
    bus.free_tag0 = '0;
    bus.free_tag1 = '0;

    #12;
    check_output("rst.gnt", int'(bus.alloc_gnt), 0);
    check_output("rst.count", int'(bus.free_count), 32);
    check_output("rst.empty", int'(bus.empty), 0);
    check_output("rst.err", int'(bus.err), 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.alloc_req = '0;

    tbl[0] = '{2'b11, 2'b00,  0,  0, 2'b11, 32, 33, 30, 1'b0};
    tbl[1] = '{2'b01, 2'b00,  0,  0, 2'b01, 34,  0, 29, 1'b0};
    tbl[2] = '{2'b10, 2'b00,  0,  0, 2'b10,  0, 35, 28, 1'b0};
    tbl[3] = '{2'b00, 2'b11, 32, 33, 2'b00,  0,  0, 30, 1'b0};
    tbl[4] = '{2'b11, 2'b01, 34,  0, 2'b11, 36, 37, 29, 1'b0};
    for (int i = 0; i < 5; i++)
      apply_stimulus($sformatf("vec%0d", i), tbl[i].req, tbl[i].vld, tbl[i].t0, tbl[i].t1,
                     tbl[i].gnt, tbl[i].e0, tbl[i].e1, tbl[i].cnt, tbl[i].emp, 1'b0);

    for (int t = 38; t <= 63; t++) fl_q.push_back(t);
    fl_q.push_back(32);
    fl_q.push_back(33);
    fl_q.push_back(34);
    out_q.push_back(35);
    out_q.push_back(36);
    out_q.push_back(37);

    for (int k = 0; k < 20 && fl_q.size() > 1; k++) run_model_cycle("drain", 2'b11, 2'b00);
    apply_stimulus("cnt1_req11", 2'b11, 2'b00, 0, 0, 2'b01, 34, 0, 0, 1'b1, 1'b0);
    out_q.push_back(fl_q.pop_front());
    apply_stimulus("cnt0_req11", 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1'b1, 1'b0);

    apply_stimulus("nobypass", 2'b01, 2'b01, 40, 0, 2'b00, 0, 0, 1, 1'b0, 1'b0);
    apply_stimulus("freed_alloc", 2'b01, 2'b00, 0, 0, 2'b01, 40, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < out_q.size(); k++)
      if (out_q[k] == 40) begin
        out_q.delete(k);
        break;
      end
    out_q.push_back(40);

    run_model_cycle("prime", 2'b00, 2'b11);
    run_model_cycle("prime", 2'b00, 2'b11);
    for (int k = 0; k < 100; k++) run_model_cycle($sformatf("wrap%0d", k), 2'b01, 2'b01);

    @(negedge clk);
    bus.alloc_req = 2'b11;
    #1;
    check_output("mid.pre_gnt", int'(bus.alloc_gnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid.gnt", int'(bus.alloc_gnt), 0);
    check_output("mid.count", int'(bus.free_count), 32);
    check_output("mid.empty", int'(bus.empty), 0);
    check_output("mid.err", int'(bus.err), 0);
    @(posedge clk);
    #1;
    check_output("mid.hold_gnt", int'(bus.alloc_gnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("mid.rel_gnt", int'(bus.alloc_gnt), 3);
    check_output("mid.rel_tag0", int'(bus.alloc_tag0), 32);
    check_output("mid.rel_tag1", int'(bus.alloc_tag1), 33);
    @(posedge clk);
    #1;
    check_output("mid.rel_count", int'(bus.free_count), 30);
    bus.alloc_req = '0;

    do_reset();
    apply_stimulus("chk.alloc", 2'b01, 2'b00, 0, 0, 2'b01, 32, 0, 31, 1'b0, 1'b0);
    apply_stimulus("chk.free_areg", 2'b00, 2'b01, 5, 0, 2'b00, 0, 0,
                   ERR_EN ? 31 : 32, 1'b0, ERR_EN);
    do_reset();
    apply_stimulus("chk.alloc2", 2'b01, 2'b00, 0, 0, 2'b01, 32, 0, 31, 1'b0, 1'b0);
    apply_stimulus("chk.free_over", 2'b00, 2'b11, 32, 40, 2'b00, 0, 0, 32, 1'b0, ERR_EN);
    apply_stimulus("chk.free_dup", 2'b00, 2'b01, 40, 0, 2'b00, 0, 0, 32, 1'b0, ERR_EN);
    apply_stimulus("chk.after", 2'b01, 2'b00, 0, 0, 2'b01, 33, 0, 31, 1'b0, ERR_EN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, total physical registers.
REQ-002 SHALL have parameter NUM_AREGS, default 32, architectural registers, always mapped.
REQ-003 SHALL have parameter DEPTH, default NUM_PREGS-NUM_AREGS (32), free-list capacity.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have alloc_req  in  2  per-slot allocation request, bit 0 = rename slot 0.
REQ-007 SHALL have alloc_gnt  out  2  per-slot grant, combinational, same cycle.
REQ-008 SHALL have alloc_tag0, alloc_tag1  out  6 each  physical tag for slot 0/1, valid when the matching gnt bit is high.
REQ-009 SHALL have free_vld  in  2  per-slot release from retire.
REQ-010 SHALL have free_tag0, free_tag1  in  6 each  tags being released.
REQ-011 SHALL have free_count  out  6  number of free tags held (0..32).
REQ-012 SHALL have empty  out  1  high when free_count==0.
REQ-013 SHALL have err  out  1  sticky protocol error (see Configuration).

Function
REQ-014 SHALL hold free tags in a DEPTH-entry circular FIFO with 5-bit head/tail pointers wrapping modulo DEPTH, plus a 6-bit count.
REQ-015 SHALL grant in slot-priority order: gnt[0]=req[0]&(count>=1); gnt[1]=req[1]&(count>=1+gnt[0]).
REQ-016 SHALL drive alloc_tag0=fifo[head], alloc_tag1=fifo[head+gnt[0]] (mod DEPTH); ungranted tags are don't-care.
REQ-017 SHALL advance head by popcount(gnt) on the clock edge.
REQ-018 SHALL write free_tag0 at tail then free_tag1 at tail+free_vld[0], advancing tail by popcount(free_vld).
REQ-019 SHALL update count = count - popcount(gnt) + popcount(accepted frees) in one edge.
REQ-020 SHALL NOT bypass: a tag freed in cycle N becomes allocatable no earlier than cycle N+1.
REQ-021 SHALL accept simultaneous alloc and free in the same cycle, including at count 0 and count DEPTH.
REQ-022 SHALL drop a free that would take count above DEPTH (slot 1 dropped first), leaving FIFO unchanged for that slot.
REQ-023 SHALL register no outputs except free_count, empty and err; grants have zero-cycle latency.

Reset
REQ-024 SHALL, on rst_n low, load fifo[i]=NUM_AREGS+i (tags 32..63), head=0, tail=0, count=32, err=0, immediately and asynchronously.
REQ-025 SHALL, during and at reset, drive alloc_gnt=0; free_count=32, empty=0 after reset.
REQ-026 SHALL abandon any in-flight alloc/free on reset mid-operation; no partial pointer update.

Configuration
REQ-027 SHALL implement, when FREE_LIST_CHECK_EN is defined, a NUM_PREGS-bit in-list bitmap; a free of a tag already in the list, a tag below NUM_AREGS, or a free dropped per REQ-022 SHALL set err and be discarded.
REQ-028 SHALL, without FREE_LIST_CHECK_EN, omit the bitmap, tie err to 0, and still apply REQ-022.

Structure
REQ-029 SHALL take NUM_PREGS, NUM_AREGS, TAG_W=6 and typedef preg_tag_t from the shared package used by rename and the RAT.
REQ-030 SHALL be a single module with no sub-modules; FIFO, pointers and checker are inline.

Verification
REQ-031 Reset, then req=2'b11 -> gnt=2'b11, tags 32,33; next cycle free_count=30.
REQ-032 Drain to count=1, req=2'b11 -> gnt=2'b01, tag0=next free; next cycle empty=1, req=2'b11 -> gnt=2'b00.
REQ-033 At count=0, req=2'b01 with free_vld=2'b01 tag 40 -> gnt=0 this cycle; next cycle gnt=2'b01, tag0=40.
REQ-034 Allocate/free 100 tags in a loop -> head/tail wrap past 31, tags returned in FIFO order, count constant.
REQ-035 With FREE_LIST_CHECK_EN, free tag 5 or free tag 40 twice -> err=1 sticky, count unchanged; without macro err stays 0.
REQ-036 Assert rst_n low while req=2'b11 mid-stream -> state reloads 32..63, count=32, gnt=0 asynchronously.
